// File: rtl/fact_seq.sv
// ============================================================================
// Module   : fact_seq (with cla4 adder slice)
// Brief    : Sequential n! controller; shift-and-add multiply over a 64-bit
//            ripple of cla4 slices, overflow flag for operands above MAX_N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    // Carries expanded from generate/propagate rather than rippled bit to bit.
    assign w_c[0] = cin_i;
    assign w_c[1] = w_g[0] | (w_p[0] & cin_i);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin_i);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin_i);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin_i);

    assign sum_o  = w_p ^ w_c[3:0];
    assign cout_o = w_c[4];
endmodule

module fact_seq #(
    parameter int MAX_N = 20
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [4:0]  n_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o,
    output logic        overflow_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] c_MAX_N = 6'(MAX_N);

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  k_q, k_d;
    logic [63:0] result_q, result_d;
    logic        overflow_q, overflow_d;

    logic [63:0] w_addend;
    logic [63:0] w_sum;
    logic [16:0] w_carry;
    logic        w_cout_unused;
    logic [63:0] w_prod_next;

    assign w_addend   = acc_q << k_q;
    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cla
            cla4 u_cla4 (
                .a_i   (prod_q[4*gi +: 4]),
                .b_i   (w_addend[4*gi +: 4]),
                .cin_i (w_carry[gi]),
                .sum_o (w_sum[4*gi +: 4]),
                .cout_o(w_carry[gi+1])
            );
        end
    endgenerate

    // Top carry cannot be set for any legal operand, so it is dropped.
    assign w_cout_unused = w_carry[16];
    assign w_prod_next   = cnt_q[k_q] ? w_sum : prod_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if ({1'b0, n_i} > c_MAX_N) begin
                        result_d   = 64'd0;
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d   = n_i;
                        acc_d   = 64'd1;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (cnt_q <= 5'd1) begin
                    result_d   = acc_q;
                    overflow_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    prod_d  = 64'd0;
                    k_d     = 3'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                prod_d = w_prod_next;
                k_d    = k_q + 3'd1;
                if (k_q == 3'd4) begin
                    acc_d   = w_prod_next;
                    cnt_d   = cnt_q - 5'd1;
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            acc_q      <= 64'd0;
            prod_q     <= 64'd0;
            cnt_q      <= 5'd0;
            k_q        <= 3'd0;
            result_q   <= 64'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign result_o   = result_q;
    assign overflow_o = overflow_q;
endmodule

`default_nettype wire

// File: tb/tb_fact_seq.sv
// ============================================================================
// Module   : tb_fact_seq
// Brief    : Scoreboard bench for fact_seq: expected n!, flag and done cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fact_seq;
    localparam int MAX_N = 20;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        start_i;
    logic [4:0]  n_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic        overflow_o;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fact_seq #(.MAX_N(MAX_N)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .start_i   (start_i),
        .n_i       (n_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fact(input int v);
        longint unsigned f = 1;
        if (v > MAX_N) return 64'd0;
        for (int i = 2; i <= v; i++) f = f * longint'(i);
        return f;
    endfunction

    function automatic int lat_of(input int v);
        if (v > MAX_N) return 1;
        if (v <= 1) return 2;
        return 6 * v - 4;
    endfunction

    // Pops one expectation per done pulse; a pulse with nothing pending is an error.
    always @(negedge clk_i) begin
        if (reset_n_i && done_o) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 64'(done_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("result", result_o, e.res);
                check_val("overflow", 64'(overflow_o), 64'(e.ovf));
                check_val("done_cycle", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    // Call at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic issue(input logic [4:0] nv, input int p1, input int p2);
        exp_t e;
        int   guard;
        int   c;
        e.res = fact(int'(nv));
        e.ovf = (int'(nv) > MAX_N);
        e.lat = lat_of(int'(nv));
        e.t0  = cyc;
        sb.push_back(e);
        start_i = 1'b1;
        n_i     = nv;
        guard   = 0;
        do begin
            @(negedge clk_i);
            c = cyc - e.t0;
            if (c == 1) check_val("busy_cycle1", 64'(busy_o), 64'd1);
            start_i = (c == p1) || (c == p2);
            n_i     = 5'd3;
            #1;
            guard++;
        end while (sb.size() != 0 && guard < 200);
        if (sb.size() != 0) begin
            check_val("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk_i);
        start_i = 1'b0;
        check_val("busy_after_done", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int t0;
        reset_n_i = 1'b0;
        start_i   = 1'b0;
        n_i       = 5'd0;
        repeat (2) @(negedge clk_i);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_done", 64'(done_o), 64'd0);
        check_val("rst_result", result_o, 64'd0);
        check_val("rst_overflow", 64'(overflow_o), 64'd0);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        issue(5'd5, 0, 0);
        issue(5'd20, 0, 0);
        issue(5'd0, 0, 0);
        issue(5'd1, 0, 0);
        issue(5'd21, 0, 0);
        issue(5'd3, 0, 0);
        issue(5'd10, 5, 56);
        issue(5'd31, 0, 0);
        issue(5'd2, 0, 0);

        // Abort n=10 at cycle 20 with a two-cycle reset pulse.
        start_i = 1'b1;
        n_i     = 5'd10;
        t0      = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        while (cyc - t0 < 20) @(negedge clk_i);
        check_val("pre_abort_busy", 64'(busy_o), 64'd1);
        reset_n_i = 1'b0;
        #1;
        check_val("abort_busy", 64'(busy_o), 64'd0);
        check_val("abort_done", 64'(done_o), 64'd0);
        check_val("abort_result", result_o, 64'd0);
        check_val("abort_overflow", 64'(overflow_o), 64'd0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (60) @(negedge clk_i);
        check_val("post_abort_busy", 64'(busy_o), 64'd0);
        check_val("post_abort_result", result_o, 64'd0);

        issue(5'd4, 0, 0);
        check_val("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
